// File: rtl/ascon_ps.sv
// ascon_ps: Ascon p_S substitution layer, one registered 320-bit state per cycle
module ascon_ps (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [4:0][63:0] psin_i,
    output logic [4:0][63:0] psout_o,
    output logic             valid_o
);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [4:0][63:0] sub;
    // bitsliced S-box: every column of the state is substituted in parallel
    always_comb begin
        a0 = psin_i[0] ^ psin_i[4];
        a1 = psin_i[1];
        a2 = psin_i[2] ^ psin_i[1];
        a3 = psin_i[3];
        a4 = psin_i[4] ^ psin_i[3];
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;
        sub[0] = b0 ^ b4;
        sub[1] = b1 ^ b0;
        sub[2] = ~b2;
        sub[3] = b3 ^ b2;
        sub[4] = b4;
    end
    // capture result on accepted input; data holds while idle, reset clears everything
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            psout_o <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= en_i;
            if (en_i) psout_o <= sub;
        end
    end
endmodule

// File: tb/tb_ascon_ps.sv
// tb_ascon_ps: table-driven check of ascon_ps against a lookup-table S-box model
module tb_ascon_ps;
    typedef logic [4:0][63:0] state_t;
    typedef struct packed {
        logic   rst;
        logic   en;
        state_t din;
        state_t exp_out;
        logic   exp_valid;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   en;
    state_t din;
    state_t dout;
    logic   valid;
    int     n_tests = 0;
    int     n_fail = 0;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    ascon_ps dut (
        .clock_i(clk),
        .reset_i(rst),
        .en_i(en),
        .psin_i(din),
        .psout_o(dout),
        .valid_o(valid)
    );

    always #5 clk = ~clk;

    function automatic state_t model(input state_t s);
        state_t r;
        logic [4:0] idx, o;
        for (int j = 0; j < 64; j++) begin
            idx = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            o = SBOX[idx];
            r[0][j] = o[4];
            r[1][j] = o[3];
            r[2][j] = o[2];
            r[3][j] = o[1];
            r[4][j] = o[0];
        end
        return r;
    endfunction

    function automatic state_t columns_0_31();
        state_t s;
        logic [4:0] v;
        s = '0;
        for (int j = 0; j < 32; j++) begin
            v = 5'(j);
            s[0][j] = v[4];
            s[1][j] = v[3];
            s[2][j] = v[2];
            s[3][j] = v[1];
            s[4][j] = v[0];
        end
        return s;
    endfunction

    function automatic state_t columns_expected();
        state_t s;
        logic [4:0] v;
        for (int j = 0; j < 64; j++) begin
            v = (j < 32) ? SBOX[j] : 5'h04;
            s[0][j] = v[4];
            s[1][j] = v[3];
            s[2][j] = v[2];
            s[3][j] = v[1];
            s[4][j] = v[0];
        end
        return s;
    endfunction

    task automatic step(input logic r, input logic e, input state_t d);
        rst = r;
        en = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input state_t exp_out, input logic exp_valid);
        n_tests++;
        if (dout !== exp_out) begin
            n_fail++;
            $display("FAIL %s psout got %h want %h", name, dout, exp_out);
        end
        n_tests++;
        if (valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s valid got %b want %b", name, valid, exp_valid);
        end
    endtask

    localparam state_t V_ZERO = '0;
    localparam state_t V_ONES = {5{64'hFFFFFFFFFFFFFFFF}};
    localparam state_t V_X4   = {64'h1, 64'h0, 64'h0, 64'h0, 64'h0};
    localparam state_t E_ZERO = {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0};
    localparam state_t E_ONES = {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                                 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF};
    localparam state_t E_X4   = {64'h1, 64'h1, 64'hFFFFFFFFFFFFFFFE, 64'h1, 64'h0};
    localparam state_t V_GOLD = {64'hc11bf1d12e77b520, 64'h8866d2abc492c960,
                                 64'h94beaba9335e441f, 64'h7559456e06c73ad3,
                                 64'h598da474303d9164};

    vec_t vecs [14];

    initial begin
        state_t junk;
        junk = {5{64'hA5A55A5A3C3CC3C3}};
        vecs[0]  = '{1'b1, 1'b0, V_ONES, V_ZERO, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, V_ONES, V_ZERO, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, V_ZERO, E_ZERO, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, V_ONES, E_ONES, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, V_X4, E_X4, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, junk, E_X4, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, V_ONES, E_X4, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, columns_0_31(), columns_expected(), 1'b1};
        vecs[8]  = '{1'b0, 1'b1, V_GOLD, model(V_GOLD), 1'b1};
        vecs[9]  = '{1'b0, 1'b1, junk, model(junk), 1'b1};
        vecs[10] = '{1'b1, 1'b1, V_ONES, V_ZERO, 1'b0};
        vecs[11] = '{1'b0, 1'b0, V_ONES, V_ZERO, 1'b0};
        vecs[12] = '{1'b0, 1'b1, V_X4, E_X4, 1'b1};
        vecs[13] = '{1'b0, 1'b0, V_ZERO, E_X4, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
        end

        // model cross-check of the hand-computed constants
        n_tests++;
        if (model(V_X4) !== E_X4 || model(V_ZERO) !== E_ZERO || model(V_ONES) !== E_ONES) begin
            n_fail++;
            $display("FAIL model_consts got %h want %h", model(V_X4), E_X4);
        end

        // back-to-back stream of three, then idle with changing input
        step(1'b0, 1'b1, V_ZERO);
        check("stream0", E_ZERO, 1'b1);
        step(1'b0, 1'b1, V_ONES);
        check("stream1", E_ONES, 1'b1);
        step(1'b0, 1'b1, V_X4);
        check("stream2", E_X4, 1'b1);
        step(1'b0, 1'b0, V_GOLD);
        check("idle0", E_X4, 1'b0);
        step(1'b0, 1'b0, V_ZERO);
        check("idle1", E_X4, 1'b0);

        // reset mid-stream discards, first input afterwards processed normally
        step(1'b0, 1'b1, V_GOLD);
        check("pre_rst", model(V_GOLD), 1'b1);
        step(1'b1, 1'b1, V_ONES);
        check("mid_rst", V_ZERO, 1'b0);
        step(1'b0, 1'b1, V_ONES);
        check("post_rst", E_ONES, 1'b1);
        step(1'b0, 1'b0, V_X4);
        check("post_idle", E_ONES, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
